// File: rtl/rx_iq_packer_pkg.sv
// Shared types and constants for the receive-side I/Q byte packer.
package rx_pkg;

  localparam int IBITS_DEF        = 24;
  localparam int DEPTH_DEF        = 16;
  localparam int BYTES_PER_SAMPLE = 2 * IBITS_DEF / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int bytes_per_sample(input int ibits);
    return 2 * ibits / 8;
  endfunction

endpackage

// File: rtl/rx_iq_packer_if.sv
// Byte stream toward the host transport.
// Handshake: a byte transfers on a clock edge where out_valid && out_ready; while out_valid is
// high and out_ready low, out_data/out_sop/out_valid hold. out_valid never depends on out_ready.
interface rx_iq_packer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;

  modport master (output out_data, output out_valid, output out_sop, input out_ready);
  modport slave  (input out_data, input out_valid, input out_sop, output out_ready);
endinterface

// File: rtl/rx_iq_packer_fifo.sv
// Register-based sample FIFO with registered pointers and level; flush empties it in one edge.
module iq_sample_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 16,
  parameter int LBITS = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [LBITS-1:0] level_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LBITS-1:0] level_q;

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_q + LBITS'(push_i) - LBITS'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/rx_iq_packer.sv
// Captures FIR I/Q samples into a FIFO and serializes each as big-endian bytes (I then Q)
// on a valid/ready byte stream, flagging samples lost to a full FIFO.
module rx_iq_packer
  import rx_pkg::*;
#(
  parameter int IBITS = IBITS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LBITS = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              strobe_in,
  input  logic [IBITS-1:0]  x_real,
  input  logic [IBITS-1:0]  x_imag,
  input  logic              run,
  input  logic              clear_ovf,
  rx_iq_packer_if.master    out_if,
  output logic              overflow,
  output logic [LBITS-1:0]  level,
  output state_e            state_o
);
  localparam int SW  = 2 * IBITS;
  localparam int BPS = bytes_per_sample(IBITS);
  localparam int CW  = $clog2(BPS);

  state_e        state_q, state_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          ovf_q, ovf_d;

  logic          accept, fifo_full, push, drop, pop, avail, hs;
  logic [SW-1:0] rd_data;

  // Fullness is judged on the registered level, so a same-edge pop never makes room.
  assign accept    = strobe_in && run;
  assign fifo_full = (level == LBITS'(DEPTH));
  assign push      = accept && !fifo_full;
  assign drop      = accept && fifo_full;
  assign avail     = run && (level != '0);
  assign hs        = valid_q && out_if.out_ready;

  iq_sample_fifo #(.W(SW), .DEPTH(DEPTH), .LBITS(LBITS)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (!run),
    .wdata_i ({x_real, x_imag}),
    .rdata_o (rd_data),
    .level_o (level)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (avail) begin
          pop     = 1'b1;
          sh_d    = rd_data;
          cnt_d   = '0;
          valid_d = 1'b1;
          sop_d   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (cnt_q != CW'(BPS - 1)) begin
            sh_d  = sh_q << 8;
            cnt_d = cnt_q + CW'(1);
            sop_d = 1'b0;
          end else if (avail) begin
            // Reload straight from the FIFO so consecutive samples leave no bubble.
            pop   = 1'b1;
            sh_d  = rd_data;
            cnt_d = '0;
            sop_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_d = drop | (ovf_q & ~clear_ovf);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_if.out_data  = sh_q[SW-1 -: 8];
  assign out_if.out_valid = valid_q;
  assign out_if.out_sop   = sop_q;
  assign overflow         = ovf_q;
  assign state_o          = state_q;

endmodule

// File: doc/rx_iq_packer.md
# rx_iq_packer

Downstream stage of the receiver decimation FIR: captures each filtered complex output sample (24-bit I/Q plus strobe) into a small sample FIFO and serializes it as a 6-byte big-endian stream toward the host transport interface, using a valid/ready handshake. Decouples the bursty FIR output from the byte-wide link, and flags sample loss on overflow.

## Interface
- IBITS, 24, I/Q sample width; must be a multiple of 8.
- DEPTH, 16, FIFO depth in samples; power of two, 4..256.
- LBITS, $clog2(DEPTH)+1, width of `level`.
- clock  in  1  single clock domain, same clock as the FIR.
- reset_n  in  1  asynchronous, active-low reset.
- strobe_in  in  1  one-cycle pulse: new sample on x_real/x_imag.
- x_real  in  IBITS  signed I sample.
- x_imag  in  IBITS  signed Q sample.
- run  in  1  1 = accept samples; 0 = drop input and flush FIFO.
- clear_ovf  in  1  synchronous clear of `overflow`.
- out_data  out  8  current stream byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts byte when valid && ready.
- out_sop  out  1  high with the first byte (I MSB) of every sample.
- overflow  out  1  sticky: at least one sample dropped because FIFO full.
- level  out  LBITS  samples currently in FIFO (excludes the one in the serializer).

## Operation
- Reset (async, reset_n=0): out_data=0, out_valid=0, out_sop=0, overflow=0, level=0, FIFO pointers=0, FSM=IDLE, byte_cnt=0.
- Write: on edge with strobe_in=1 and run=1, {x_real,x_imag} written if level<DEPTH, judged on the registered level before this edge's pop; otherwise dropped and overflow set. Same-edge write and pop at level==DEPTH: write dropped, pop proceeds.
- clear_ovf=1 clears overflow; if a drop occurs on the same edge, overflow stays 1 (set wins).
- Byte order per sample: I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0] (generalises to IBITS/8 bytes each, MSB first).
- FSM states:
  - IDLE: out_valid=0. If level>0: pop head into 48-bit shift register, out_data=I MSB, out_sop=1, out_valid=1, byte_cnt=0, go to SEND.
  - SEND: on handshake with byte_cnt<5: shift, byte_cnt+1, out_sop=0. On handshake with byte_cnt==5: if level>0, pop and reload (byte_cnt=0, out_sop=1, stay SEND, no bubble); else out_valid=0, go to IDLE.
- Without handshake, out_data/out_sop/out_valid hold unchanged.
- run=0: strobe_in ignored (no overflow), FIFO flushed (level=0) on that edge; a sample already in the serializer completes all 6 bytes, so the consumer never sees a partial sample. run=0 never forces overflow.
- Reset mid-sample aborts immediately; the partial sample is lost by design.

## Timing
- Capture edge k (FSM IDLE, FIFO empty): level=1 after edge k, out_valid=1 with I MSB after edge k+1.
- Sustained throughput: 1 byte/clock with out_ready=1; 6 clocks per sample, zero-bubble between samples.
- Total storage with stalled consumer: DEPTH in FIFO + 1 in serializer.
- level updates on the edge of write/pop; simultaneous write+pop leaves level unchanged.
- All outputs registered; no combinational path from out_ready to out_valid/out_data.

## Structure
- Shared package rx_pkg: BYTES_PER_SAMPLE = 2*IBITS/8, state enum {IDLE, SEND}.
- Sub-module iq_sample_fifo: 2*IBITS-wide, DEPTH-deep, registered pointers and level, push/pop/flush; synchronous-read RAM permitted only if the pop-to-out_data timing above is kept (otherwise register-based storage).
- Top holds FSM, shift register, byte counter and overflow logic.

## Test plan
- Single sample I=0x123456, Q=0xABCDEF, out_ready=1 -> bytes 12 34 56 AB CD EF on 6 consecutive clocks, out_sop only on 0x12, out_valid 1 clock after capture.
- Back-to-back: 4 strobes 6 clocks apart, ready=1 -> 24 contiguous valid bytes, no gap, out_sop every 6th byte.
- Backpressure: out_ready pseudo-random 50 % -> out_data/out_sop stable while valid&&!ready, byte stream identical to ready=1 case.
- Overflow: DEPTH=16, ready=0, 18 strobes -> 17 accepted (level=16), 18th dropped, overflow=1; clear_ovf pulse -> overflow=0; release ready -> exactly 17 samples, 102 bytes, in order.
- run drop: run=0 after byte 2 of sample A with 3 samples queued -> A completes (bytes 3-5), level=0, then out_valid=0; strobes during run=0 do not set overflow.
- Reset mid-transfer: reset_n low during byte 3 -> all outputs at reset values immediately; after release, first new strobe produces a clean 6-byte sample with out_sop.
